// File: rtl/vr16_pkg.sv
// VR16 shared definitions: datapath widths, opcodes shared with the decoder,
// and the fetch-stage state encoding.
package vr16_pkg;

   localparam int unsigned VR16_ADDR_WIDTH  = 12;
   localparam int unsigned VR16_INSTR_WIDTH = 16;

   localparam logic [3:0] OP_JUMP = 4'b1001;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic {
      FS_RUN    = 1'b0,
      FS_HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, decoder-facing
// instruction output, and the redirect/halt controls coming back from decode.
interface instruction_fetch_if
   import vr16_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = VR16_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH = VR16_INSTR_WIDTH
);

   logic                   imem_req;
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   decode_stall;
   logic                   redirect_valid;
   logic [ADDR_WIDTH-1:0]  redirect_address;
   logic                   halt;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instruction_valid;
   logic [ADDR_WIDTH-1:0]  pc;
   logic                   halted;

   modport master (
      output imem_req, imem_addr, instruction, instruction_valid, pc, halted,
      input  imem_rdata, decode_stall, redirect_valid, redirect_address, halt
   );

   modport slave (
      input  imem_req, imem_addr, instruction, instruction_valid, pc, halted,
      output imem_rdata, decode_stall, redirect_valid, redirect_address, halt
   );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register that catches the in-flight
// response while the decoder stalls the fetch output.
module fetch_skid_buffer
   import vr16_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = VR16_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH = VR16_INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   drain,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [ADDR_WIDTH-1:0]  in_pc,
   output logic [INSTR_WIDTH-1:0] held_instr,
   output logic [ADDR_WIDTH-1:0]  held_pc,
   output logic                   full
);

   // load wins over drain so a simultaneous drain+refill keeps the entry full
   always_ff @(posedge clk) begin
      if (reset) begin
         full       <= 1'b0;
         held_instr <= '0;
         held_pc    <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (load) begin
         full       <= 1'b1;
         held_instr <= in_instr;
         held_pc    <= in_pc;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// VR16 fetch stage: owns the PC, issues one synchronous imem read per cycle,
// presents instruction/pc to decode with stall skid, JUMP redirect and HALT.
module instruction_fetch
   import vr16_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH  = VR16_ADDR_WIDTH,
   parameter int unsigned          INSTR_WIDTH = VR16_INSTR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic                 clk,
   input logic                 reset,
   instruction_fetch_if.master bus
);

   fetch_state_t           state, state_next;
   logic [ADDR_WIDTH-1:0]  fetch_pc, inflight_pc;
   logic                   inflight;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic [ADDR_WIDTH-1:0]  out_pc;
   logic                   out_valid;
   logic                   skid_full, skid_load, skid_drain, skid_flush;
   logic [INSTR_WIDTH-1:0] skid_instr;
   logic [ADDR_WIDTH-1:0]  skid_pc;
   logic                   run, kill, out_stalled, out_take, req;

   always_ff @(posedge clk) begin
      if (reset) state <= FS_RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state == FS_RUN && bus.halt) state_next = FS_HALTED;
   end

   always_comb begin
      run         = (state == FS_RUN);
      kill        = run && (bus.halt || bus.redirect_valid);
      out_stalled = out_valid && bus.decode_stall;
      out_take    = !out_stalled;
      // never issue a request whose response would have nowhere to land
      req         = run && !reset && !bus.halt && !bus.redirect_valid && !skid_full
                    && !(out_stalled && inflight);
      skid_flush  = kill;
      skid_drain  = out_take && skid_full;
      skid_load   = inflight && (out_stalled || skid_full);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         out_instr   <= '0;
         out_pc      <= '0;
         out_valid   <= 1'b0;
      end else if (kill) begin
         inflight  <= 1'b0;
         out_valid <= 1'b0;
         if (!bus.halt) fetch_pc <= bus.redirect_address;
      end else if (run) begin
         inflight <= req;
         if (req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 1'b1;
         end
         // skid content is older than the in-flight response, so it goes first
         if (out_take) begin
            if (skid_full) begin
               out_instr <= skid_instr;
               out_pc    <= skid_pc;
               out_valid <= 1'b1;
            end else if (inflight) begin
               out_instr <= bus.imem_rdata;
               out_pc    <= inflight_pc;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   fetch_skid_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INSTR_WIDTH(INSTR_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .drain     (skid_drain),
      .flush     (skid_flush),
      .in_instr  (bus.imem_rdata),
      .in_pc     (inflight_pc),
      .held_instr(skid_instr),
      .held_pc   (skid_pc),
      .full      (skid_full)
   );

   assign bus.imem_req          = req;
   assign bus.imem_addr         = fetch_pc;
   assign bus.instruction       = out_instr;
   assign bus.instruction_valid = out_valid;
   assign bus.pc                = out_pc;
   assign bus.halted            = (state == FS_HALTED);

endmodule
